sii_i2c_init: RTL and testbench

SII_I2C_INIT -- requirements
Module: sii_i2c_init

---
 rtl/sii_i2c_init.sv | 182 ++++++++++++++++++
 tb/tb_sii_i2c_init.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sii_i2c_init.sv
// sii_i2c_init: pulses the SiI chip reset, then writes a register table over I2C
// as {dev,W} reg data transfers, retrying NACKed entries up to MAX_RETRY times.
module sii_i2c_init #(
  parameter int CLK_DIV      = 62,
  parameter int RST_HOLD_CYC = 250000,
  parameter int RST_WAIT_CYC = 125000,
  parameter int MAX_RETRY    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        chip_reset_n,
  output logic        scl_oe,
  output logic        sda_oe,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic [5:0]  tbl_idx,
  input  logic [23:0] tbl_entry
);
  localparam int DMAX = RST_HOLD_CYC > RST_WAIT_CYC ? RST_HOLD_CYC : RST_WAIT_CYC;
  localparam int DW = $clog2(DMAX + 1) > 18 ? $clog2(DMAX + 1) : 18;
  localparam int QW = $clog2(CLK_DIV + 1);
  localparam int RW = $clog2(MAX_RETRY + 1) > 0 ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [QW-1:0] QLAST = QW'(CLK_DIV - 1);
  localparam logic [DW-1:0] HLAST = DW'(RST_HOLD_CYC - 1);
  localparam logic [DW-1:0] WLAST = DW'(RST_WAIT_CYC - 1);
  localparam logic [RW-1:0] RMAX  = RW'(MAX_RETRY);
  typedef enum logic [3:0] {IDLE, RST_HOLD, RST_WAIT, FETCH, START, BYTE, ACK, STOP, NEXT, DONE, ERR} state_t;
  state_t st, st_n;
  logic [QW-1:0] qcnt, qcnt_n;
  logic [DW-1:0] dly, dly_n;
  logic [1:0] ph, ph_n, byte_cnt, byte_n;
  logic [2:0] bit_cnt, bit_n;
  logic [RW-1:0] retries, retry_n;
  logic nack, nack_n;
  logic [22:0] ent, ent_n;
  logic [5:0] idx_n;
  logic quarter, stall, tick, scl_nx, sda_nx, chip_nx;
  logic [7:0] byte_v;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      st <= IDLE;
      qcnt <= '0;
      dly <= '0;
      ph <= '0;
      byte_cnt <= '0;
      bit_cnt <= '0;
      retries <= '0;
      nack <= 1'b0;
      ent <= '0;
      tbl_idx <= '0;
      chip_reset_n <= 1'b0;
      scl_oe <= 1'b0;
      sda_oe <= 1'b0;
    end else begin
      st <= st_n;
      qcnt <= qcnt_n;
      dly <= dly_n;
      ph <= ph_n;
      byte_cnt <= byte_n;
      bit_cnt <= bit_n;
      retries <= retry_n;
      nack <= nack_n;
      ent <= ent_n;
      tbl_idx <= idx_n;
      chip_reset_n <= chip_nx;
      scl_oe <= scl_nx;
      sda_oe <= sda_nx;
    end
  // a released SCL that still reads low is a slave stretching the clock
  assign quarter = st inside {START, BYTE, ACK, STOP};
  assign stall = !scl_oe && !scl_in;
  assign tick = quarter && qcnt == QLAST && !stall;
  always_comb begin
    st_n = st;
    dly_n = dly;
    ph_n = ph;
    bit_n = bit_cnt;
    byte_n = byte_cnt;
    retry_n = retries;
    nack_n = nack;
    ent_n = ent;
    idx_n = tbl_idx;
    qcnt_n = !quarter ? '0 : stall ? qcnt : tick ? '0 : qcnt + 1'b1;
    case (st)
      IDLE, DONE, ERR:
        if (start) begin
          st_n = RST_HOLD;
          dly_n = '0;
          idx_n = '0;
          retry_n = '0;
        end
      RST_HOLD: begin
        dly_n = dly == HLAST ? '0 : dly + 1'b1;
        st_n = dly == HLAST ? RST_WAIT : RST_HOLD;
      end
      RST_WAIT: begin
        dly_n = dly == WLAST ? '0 : dly + 1'b1;
        st_n = dly == WLAST ? FETCH : RST_WAIT;
        ph_n = '0;
      end
      FETCH: begin
        ph_n = ph[0] ? 2'd0 : 2'd1;
        if (ph[0]) begin
          ent_n = {tbl_entry[23:17], tbl_entry[15:0]};
          st_n = tbl_entry[16] ? DONE : START;
        end
      end
      START:
        if (tick) begin
          ph_n = ph == 2'd2 ? 2'd0 : ph + 1'b1;
          if (ph == 2'd2) begin
            st_n = BYTE;
            bit_n = 3'd7;
            byte_n = '0;
            nack_n = 1'b0;
          end
        end
      BYTE:
        if (tick) begin
          ph_n = ph + 1'b1;
          if (ph == 2'd3) begin
            bit_n = bit_cnt - 1'b1;
            st_n = bit_cnt == 3'd0 ? ACK : BYTE;
          end
        end
      ACK:
        if (tick) begin
          ph_n = ph + 1'b1;
          if (ph == 2'd2) nack_n = sda_in;
          if (ph == 2'd3) begin
            byte_n = byte_cnt + 1'b1;
            st_n = (nack || byte_cnt == 2'd2) ? STOP : BYTE;
          end
        end
      STOP:
        if (tick) begin
          ph_n = ph == 2'd2 ? 2'd0 : ph + 1'b1;
          if (ph == 2'd2) begin
            st_n = !nack ? NEXT : retries == RMAX ? ERR : START;
            retry_n = (nack && retries != RMAX) ? retries + 1'b1 : retries;
          end
        end
      NEXT: begin
        idx_n = tbl_idx + 1'b1;
        retry_n = '0;
        ph_n = '0;
        st_n = tbl_idx == 6'd63 ? DONE : FETCH;
      end
      default: st_n = IDLE;
    endcase
  end
  // bus levels follow the next state so the registered oe lines line up with the phase
  always_comb begin
    busy = !(st inside {IDLE, DONE, ERR});
    done = st == DONE;
    error = st == ERR;
    chip_nx = !(st_n inside {IDLE, RST_HOLD});
    byte_v = byte_n == 2'd0 ? {ent_n[22:16], 1'b0} : byte_n == 2'd1 ? ent_n[15:8] : ent_n[7:0];
    scl_nx = 1'b0;
    sda_nx = 1'b0;
    case (st_n)
      START: begin
        scl_nx = ph_n == 2'd2;
        sda_nx = ph_n != 2'd0;
      end
      BYTE: begin
        scl_nx = ph_n == 2'd0 || ph_n == 2'd3;
        sda_nx = !byte_v[bit_n];
      end
      ACK: scl_nx = ph_n == 2'd0 || ph_n == 2'd3;
      STOP: begin
        scl_nx = ph_n == 2'd0;
        sda_nx = ph_n != 2'd2;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_sii_i2c_init.sv
// tb_sii_i2c_init: I2C slave model with a byte scoreboard for sii_i2c_init
module tb_sii_i2c_init;
  localparam logic [23:0] END_E = 24'h010000;
  logic clk, reset, start, busy, done, error, chip_reset_n, scl_oe, sda_oe, scl_in, sda_in;
  logic [5:0] tbl_idx;
  logic [23:0] tbl_entry;
  logic [23:0] tbl [64];
  logic s_sda, hold, nack_all, nack_first1, stretch;
  logic [7:0] sh;
  logic [7:0] exp_q [$];
  int hcnt, n_start, n_stop, txn, bc, byte_no, cyc, n_chk, n_fail;
  int fall_t [10];

  sii_i2c_init #(.CLK_DIV(4), .RST_HOLD_CYC(20), .RST_WAIT_CYC(10), .MAX_RETRY(3)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .error(error),
    .chip_reset_n(chip_reset_n), .scl_oe(scl_oe), .sda_oe(sda_oe), .scl_in(scl_in),
    .sda_in(sda_in), .tbl_idx(tbl_idx), .tbl_entry(tbl_entry)
  );

  assign scl_in = !scl_oe && !hold;
  assign sda_in = !sda_oe && !s_sda;
  assign tbl_entry = tbl[tbl_idx];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] ent(input logic [6:0] dv, input logic [7:0] r, input logic [7:0] d);
    return {dv, 1'b0, r, d};
  endfunction

  task automatic push3(input logic [6:0] dv, input logic [7:0] r, input logic [7:0] d);
    exp_q.push_back({dv, 1'b0});
    exp_q.push_back(r);
    exp_q.push_back(d);
  endtask

  // decodes the bus at negedge, pops the scoreboard per byte, drives ACK and stretching
  task automatic monitor();
    logic ps, pd, s, d;
    ps = 1'b1;
    pd = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      s = scl_in;
      d = sda_in;
      if (ps && s && pd && !d) begin
        n_start++;
        txn++;
        bc = 0;
        byte_no = 0;
      end else if (ps && s && !pd && d) n_stop++;
      else if (!ps && s) begin
        if (bc < 8) begin
          sh = {sh[6:0], d};
          if (bc == 7) begin
            check("bus_byte_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) check("bus_byte", 32'(sh), 32'(exp_q.pop_front()));
          end
        end
        bc++;
      end else if (ps && !s) begin
        if (byte_no == 1 && bc < 10) fall_t[bc] = cyc;
        if (stretch && byte_no == 1 && bc == 4) begin
          hold = 1'b1;
          hcnt = 0;
        end
        if (bc == 8) s_sda = !((nack_all || (nack_first1 && txn == 2)) && byte_no == 0);
        else if (bc == 9) begin
          s_sda = 1'b0;
          bc = 0;
          byte_no++;
        end
      end
      if (hold && !scl_oe) begin
        if (hcnt == 50) hold = 1'b0;
        else hcnt++;
      end
      ps = s;
      pd = d;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    s_sda = 1'b0;
    hold = 1'b0;
    n_start = 0;
    n_stop = 0;
    txn = 0;
    bc = 0;
    byte_no = 0;
    exp_q.delete();
    for (int i = 0; i < 64; i++) tbl[i] = END_E;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input string name);
    int n = 0;
    while (!(done || error) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_finished"}, 32'(done || error), 32'd1);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    start = 1'b0;
    s_sda = 1'b0;
    hold = 1'b0;
    nack_all = 1'b0;
    nack_first1 = 1'b0;
    stretch = 1'b0;
    n_chk = 0;
    n_fail = 0;
    cyc = 0;
    sh = '0;
    for (int i = 0; i < 64; i++) tbl[i] = END_E;
    fork
      monitor();
    join_none
    do_reset();
    check("rst_scl_oe", 32'(scl_oe), 32'd0);
    check("rst_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_chip_reset_n", 32'(chip_reset_n), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_tbl_idx", 32'(tbl_idx), 32'd0);
    repeat (30) @(negedge clk);
    check("idle_chip_reset_n", 32'(chip_reset_n), 32'd0);

    // single entry, all ACK
    tbl[0] = ent(7'h39, 8'h08, 8'h05);
    push3(7'h39, 8'h08, 8'h05);
    pulse_start();
    wait_end("t1");
    check("t1_done", 32'(done), 32'd1);
    check("t1_error", 32'(error), 32'd0);
    check("t1_tbl_idx", 32'(tbl_idx), 32'd1);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_chip_reset_n", 32'(chip_reset_n), 32'd1);
    check("t1_starts", 32'(n_start), 32'd1);
    check("t1_stops", 32'(n_stop), 32'd1);
    check("t1_queue_left", 32'(exp_q.size()), 32'd0);

    // address always NACKed: 1 try + 3 retries, then ERR
    do_reset();
    nack_all = 1'b1;
    tbl[0] = ent(7'h39, 8'h08, 8'h05);
    repeat (4) exp_q.push_back(8'h72);
    pulse_start();
    wait_end("t2");
    nack_all = 1'b0;
    check("t2_error", 32'(error), 32'd1);
    check("t2_done", 32'(done), 32'd0);
    check("t2_tbl_idx", 32'(tbl_idx), 32'd0);
    check("t2_starts", 32'(n_start), 32'd4);
    check("t2_stops", 32'(n_stop), 32'd4);
    check("t2_queue_left", 32'(exp_q.size()), 32'd0);

    // first attempt of entry 1 NACKed once
    do_reset();
    nack_first1 = 1'b1;
    tbl[0] = ent(7'h39, 8'h08, 8'h05);
    tbl[1] = ent(7'h39, 8'h10, 8'hA5);
    push3(7'h39, 8'h08, 8'h05);
    exp_q.push_back(8'h72);
    push3(7'h39, 8'h10, 8'hA5);
    pulse_start();
    wait_end("t3");
    nack_first1 = 1'b0;
    check("t3_done", 32'(done), 32'd1);
    check("t3_tbl_idx", 32'(tbl_idx), 32'd2);
    check("t3_starts", 32'(n_start), 32'd3);
    check("t3_stops", 32'(n_stop), 32'd3);
    check("t3_queue_left", 32'(exp_q.size()), 32'd0);

    // SCL stretched 50 cycles during bit 3 of the register byte
    do_reset();
    stretch = 1'b1;
    tbl[0] = ent(7'h39, 8'h5A, 8'hC3);
    push3(7'h39, 8'h5A, 8'hC3);
    pulse_start();
    wait_end("t4");
    stretch = 1'b0;
    check("t4_bit4_period", 32'(fall_t[4] - fall_t[3]), 32'd16);
    check("t4_bit3_period", 32'(fall_t[5] - fall_t[4]), 32'd66);
    check("t4_bit2_period", 32'(fall_t[6] - fall_t[5]), 32'd16);
    check("t4_done", 32'(done), 32'd1);
    check("t4_queue_left", 32'(exp_q.size()), 32'd0);

    // asynchronous reset while the data byte is on the bus
    do_reset();
    tbl[0] = ent(7'h39, 8'h08, 8'h05);
    exp_q.push_back(8'h72);
    exp_q.push_back(8'h08);
    pulse_start();
    n = 0;
    while (!(byte_no == 2 && sda_oe && scl_oe) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("t5_in_data_byte", 32'(byte_no == 2 && sda_oe && scl_oe), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("t5_scl_oe", 32'(scl_oe), 32'd0);
    check("t5_sda_oe", 32'(sda_oe), 32'd0);
    check("t5_chip_reset_n", 32'(chip_reset_n), 32'd0);
    @(negedge clk);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_queue_left", 32'(exp_q.size()), 32'd0);

    // start ignored while busy, honoured in DONE with a full chip reset
    do_reset();
    tbl[0] = ent(7'h39, 8'h08, 8'h05);
    push3(7'h39, 8'h08, 8'h05);
    pulse_start();
    n = 0;
    while (byte_no != 1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("t6_reached_byte", 32'(byte_no), 32'd1);
    pulse_start();
    check("t6_busy_start_chip", 32'(chip_reset_n), 32'd1);
    check("t6_busy_start_busy", 32'(busy), 32'd1);
    wait_end("t6a");
    check("t6a_done", 32'(done), 32'd1);
    check("t6a_starts", 32'(n_start), 32'd1);
    check("t6a_queue_left", 32'(exp_q.size()), 32'd0);
    push3(7'h39, 8'h08, 8'h05);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!chip_reset_n && n < 1000) begin
      n++;
      @(negedge clk);
    end
    check("t6_chip_reset_low_cycles", 32'(n), 32'd20);
    wait_end("t6b");
    check("t6b_done", 32'(done), 32'd1);
    check("t6b_tbl_idx", 32'(tbl_idx), 32'd1);
    check("t6b_starts", 32'(n_start), 32'd2);
    check("t6b_queue_left", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
